dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Blocking, direct-mapped, write-back/write-allocate data-cache controller for the RV32 core.
- Owns the tag, valid and dirty state for every line, and holds the line data in a sub-module.
- Sequences hit detection, dirty-line writeback and line refill over a word-wide, ready/valid memory port.
- Exposes a simple request interface to the core, with a stall signal.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, word width.
- LINE_WORDS, 4, words per line; must be a power of two.
- INDEX_W, 6, index bits, giving 64 lines.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cpu_req_valid  in  1  core request present.
- cpu_req_we  in  1  1 = store, 0 = load.
- cpu_req_addr  in  ADDR_W  byte address; bits [1:0] are ignored.
- cpu_req_wdata  in  DATA_W  store data, full word.
- cpu_ready  out  1  controller idle; a request is accepted this cycle.
- cpu_resp_valid  out  1  one-cycle pulse marking completion of an accepted request.
- cpu_resp_rdata  out  DATA_W  load data; valid only with cpu_resp_valid.
- mem_req_valid  out  1  memory beat request.
- mem_req_we  out  1  1 = writeback beat, 0 = refill read.
- mem_req_addr  out  ADDR_W  word-aligned beat address.
- mem_req_wdata  out  DATA_W  writeback data.
- mem_req_ready  in  1  memory accepts the beat.
- mem_resp_valid  in  1  refill word returned.
- mem_resp_rdata  in  DATA_W  refill word.

Behaviour:
- Address split:
  - offset = addr[1:0]
  - word = addr[2 +: log2(LINE_WORDS)]
  - index = next INDEX_W bits
  - tag = remaining upper bits
- Reset:
  - State goes to IDLE.
  - All valid and dirty bits are cleared; the beat counter is cleared.
  - cpu_resp_valid, mem_req_valid, mem_req_we, mem_req_addr and mem_req_wdata are 0.
  - cpu_ready is 1 after reset.
  - The data array is not reset.
- Reset mid-operation: the transaction is abandoned immediately and mem_req_valid drops asynchronously. Dirty data is lost; this is accepted.
- IDLE:
  - cpu_ready = 1.
  - When cpu_req_valid is high, latch we/addr/wdata and go to LOOKUP.
  - cpu_req_* is ignored in every other state.
- LOOKUP: hit = valid[index] && tag_q[index] == tag.
  - Hit on a load: cpu_resp_valid = 1 with the addressed word; go to IDLE.
  - Hit on a store: write the word, set dirty[index], pulse cpu_resp_valid (rdata don't-care); go to IDLE.
  - Miss with valid && dirty: beat counter = 0; go to WRITEBACK.
  - Otherwise: beat counter = 0; go to REFILL_REQ.
- WRITEBACK:
  - Drive mem_req_valid = 1, we = 1.
  - addr = {stored tag, index, beat counter, 2'b00}.
  - wdata = data[index][beat counter].
  - The beat completes on mem_req_valid && mem_req_ready, and the counter increments.
  - After beat LINE_WORDS-1, the counter wraps to 0, dirty[index] is cleared, and the state goes to REFILL_REQ.
- REFILL_REQ:
  - Drive mem_req_valid = 1, we = 0, addr = {req tag, index, beat counter, 2'b00}.
  - Hold until mem_req_ready, then go to REFILL_WAIT.
- REFILL_WAIT:
  - mem_req_valid = 0.
  - On mem_resp_valid, write mem_resp_rdata to data[index][beat counter] and increment the counter.
  - If that was the last beat: set tag and valid, clear dirty, go to LOOKUP; the re-lookup then hits.
  - Otherwise go to REFILL_REQ.
- Outside REFILL_WAIT, mem_resp_valid is ignored.
- Memory request outputs stay stable while mem_req_valid && !mem_req_ready.
- Latency:
  - Hit: 2 cycles from acceptance (IDLE, then LOOKUP).
  - Clean miss: 2 + LINE_WORDS × (req + resp cycles) + 1.
- The core must hold the request until cpu_resp_valid. The core stall is cpu_req_valid && !cpu_resp_valid.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT}
  - derived widths TAG_W, WORD_W, OFFSET_W
  - address-field extraction functions
- Sub-module dcache_data_ram:
  - LINE_WORDS × 2^INDEX_W words.
  - One synchronous write port.
  - Asynchronous read addressed by {index, word}.

Test Plan:
- Reset, then load 0x0000_0040 with memory returning 0xA0..0xA3 per beat → 4 read beats at 0x40, 0x44, 0x48, 0x4C; cpu_resp_rdata = 0xA0; dirty = 0.
- Immediate reload of 0x0000_0048 → hit; cpu_resp_valid in the 2nd cycle with 0xA2; no mem_req_valid.
- Store 0xDEAD_BEEF to 0x44, then load 0x0000_0444 (same index 4, different tag) → writeback of 4 beats at 0x40..0x4C carrying 0xA0, 0xDEADBEEF, 0xA2, 0xA3; then refill at 0x440..0x44C.
- mem_req_ready held low for 5 cycles during WRITEBACK beat 2 → addr/wdata stable; no beat skipped; counter advances only on handshake.
- rst_n asserted during REFILL_WAIT beat 1 → mem_req_valid = 0 asynchronously; the next load to the same address misses (valid cleared).
- Spurious mem_resp_valid in IDLE and a cpu_req_valid toggle during REFILL → no state or data change.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data-cache controller.
// Holds the geometry constants, the controller state encoding and the
// helpers that slice a byte address into offset / word / index / tag.
package dcache_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam int INDEX_W    = 6;

    localparam int OFFSET_W  = 2;
    localparam int WORD_W    = $clog2(LINE_WORDS);
    localparam int TAG_W     = ADDR_W - INDEX_W - WORD_W - OFFSET_W;
    localparam int LINES     = 1 << INDEX_W;
    localparam int RAM_AW    = INDEX_W + WORD_W;
    localparam int RAM_DEPTH = 1 << RAM_AW;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOOKUP      = 3'd1,
        WRITEBACK   = 3'd2,
        REFILL_REQ  = 3'd3,
        REFILL_WAIT = 3'd4
    } state_e;

    function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: WORD_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W + WORD_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    // Word-aligned address of one beat of a line.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0]   t,
                                                     input logic [INDEX_W-1:0] i,
                                                     input logic [WORD_W-1:0]  w);
        return {t, i, w, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// Line data storage: LINE_WORDS words per line, one line per index.
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata asynchronous read.
// Addresses are {index, word}. Contents are deliberately not reset.
module dcache_data_ram
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RAM_AW-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [RAM_DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/dcache_ctrl.sv
// Blocking direct-mapped write-back / write-allocate data-cache controller.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cpu_req_valid/we/addr/wdata     core request (sampled only in IDLE)
//   cpu_ready                       controller idle, request accepted
//   cpu_resp_valid/rdata            one-cycle completion pulse, load data
//   mem_req_valid/we/addr/wdata     word-wide memory beat request
//   mem_req_ready                   memory accepts the beat
//   mem_resp_valid/rdata            refill word return
// Outputs are decoded from registered state only, so the memory request
// is stable while stalled and collapses immediately with rst_n.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_ready,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    state_e             state_r, state_s;
    logic [WORD_W-1:0]  beat_r;
    logic [LINES-1:0]   valid_r, dirty_r;
    logic [TAG_W-1:0]   tag_r [LINES];
    logic               req_we_r;
    logic [ADDR_W-1:0]  req_addr_r;
    logic [DATA_W-1:0]  req_wdata_r;

    logic [INDEX_W-1:0] idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic [WORD_W-1:0]  word_s;
    logic               hit_s, last_beat_s;
    logic               ram_we_s;
    logic [RAM_AW-1:0]  ram_waddr_s, ram_raddr_s;
    logic [DATA_W-1:0]  ram_wdata_s, ram_rdata_s;
    logic               offset_unused_s;

    assign idx_s           = addr_index(req_addr_r);
    assign tag_s           = addr_tag(req_addr_r);
    assign word_s          = addr_word(req_addr_r);
    assign hit_s           = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    assign last_beat_s     = (beat_r == WORD_W'(LINE_WORDS - 1));
    // Byte offset is irrelevant for full-word accesses.
    assign offset_unused_s = ^req_addr_r[OFFSET_W-1:0];

    dcache_data_ram u_data_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .raddr (ram_raddr_s),
        .rdata (ram_rdata_s)
    );

    // Next-state, core/memory outputs and data-array port control.
    always_comb begin
        state_s        = state_r;
        cpu_ready      = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_rdata = '0;
        mem_req_valid  = 1'b0;
        mem_req_we     = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;
        ram_we_s       = 1'b0;
        ram_waddr_s    = {idx_s, word_s};
        ram_wdata_s    = req_wdata_r;
        ram_raddr_s    = {idx_s, word_s};
        case (state_r)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req_valid) begin
                    state_s = LOOKUP;
                end else begin
                    state_s = IDLE;
                end
            end
            LOOKUP: begin
                if (hit_s) begin
                    cpu_resp_valid = 1'b1;
                    state_s        = IDLE;
                    if (req_we_r) begin
                        ram_we_s = 1'b1;
                    end else begin
                        cpu_resp_rdata = ram_rdata_s;
                    end
                end else if (valid_r[idx_s] && dirty_r[idx_s]) begin
                    state_s = WRITEBACK;
                end else begin
                    state_s = REFILL_REQ;
                end
            end
            WRITEBACK: begin
                // The victim line is addressed with its stored tag, not the request tag.
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = beat_addr(tag_r[idx_s], idx_s, beat_r);
                ram_raddr_s   = {idx_s, beat_r};
                mem_req_wdata = ram_rdata_s;
                if (mem_req_ready && last_beat_s) begin
                    state_s = REFILL_REQ;
                end else begin
                    state_s = WRITEBACK;
                end
            end
            REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = beat_addr(tag_s, idx_s, beat_r);
                if (mem_req_ready) begin
                    state_s = REFILL_WAIT;
                end else begin
                    state_s = REFILL_REQ;
                end
            end
            REFILL_WAIT: begin
                if (mem_resp_valid) begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = {idx_s, beat_r};
                    ram_wdata_s = mem_resp_rdata;
                    if (last_beat_s) begin
                        state_s = LOOKUP;
                    end else begin
                        state_s = REFILL_REQ;
                    end
                end else begin
                    state_s = REFILL_WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, beat counter, request latch and per-line valid/dirty bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            beat_r      <= '0;
            valid_r     <= '0;
            dirty_r     <= '0;
            req_we_r    <= 1'b0;
            req_addr_r  <= '0;
            req_wdata_r <= '0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (cpu_req_valid) begin
                        req_we_r    <= cpu_req_we;
                        req_addr_r  <= cpu_req_addr;
                        req_wdata_r <= cpu_req_wdata;
                    end
                end
                LOOKUP: begin
                    if (hit_s) begin
                        if (req_we_r) begin
                            dirty_r[idx_s] <= 1'b1;
                        end
                    end else begin
                        beat_r <= '0;
                    end
                end
                WRITEBACK: begin
                    if (mem_req_ready) begin
                        beat_r <= beat_r + WORD_W'(1);
                        if (last_beat_s) begin
                            dirty_r[idx_s] <= 1'b0;
                        end
                    end
                end
                REFILL_WAIT: begin
                    if (mem_resp_valid) begin
                        beat_r <= beat_r + WORD_W'(1);
                        if (last_beat_s) begin
                            valid_r[idx_s] <= 1'b1;
                            dirty_r[idx_s] <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Tag array: written once the final refill word has arrived.
    always_ff @(posedge clk) begin
        if ((state_r == REFILL_WAIT) && mem_resp_valid && last_beat_s) begin
            tag_r[idx_s] <= tag_s;
        end
    end

endmodule
